axi4_protocol_checker: RTL and testbench
========================================

# axi4_protocol_checker

Passive, synthesisable AXI4 protocol checker and transaction counter that sits beside the memory-mapped slave on the same `arb_if` bus and replaces file-based logging with hardware checks. It tracks outstanding write and read bursts, counts beats against `AWLEN`/`ARLEN`, and enforces `VALID`/payload stability and `xLAST` placement. It reports violations through sticky flags, a one-cycle pulse, the first-error code and saturating counters, so both the bench and on-chip debug can use it.

## Interface
- `DATA_WIDTH`, 32, `WDATA`/`RDATA` width.
- `ADDR_WIDTH`, 10, `AWADDR`/`ARADDR` width.
- `LEN_WIDTH`, 8, `AWLEN`/`ARLEN` width.
- `MAX_OUTST`, 4, outstanding bursts tracked per direction; power of two, at least 2.
- `CNT_WIDTH`, 16, width of each statistics counter.

Ports:
- `ACLK`  in  1  the block's single clock.
- `ARESETn`  in  1  asynchronous reset, active-low.
- `chk_clr`  in  1  synchronous clear of flags, first-error state and counters. Does not clear the burst trackers.
- `AW*`, `W*`, `B*`, `AR*`, `R*`  in  per AXI4  every address, data, response, valid, ready and last signal of the five channels. All are inputs; the block has no bus outputs.
- `err_sticky`  out  12  one bit per error, set on detection, held until `chk_clr`.
- `err_pulse`  out  1  high for one cycle per cycle in which any error is detected.
- `first_err`  out  4  index of the first error since reset or clear; valid while `first_err_vld` is high.
- `first_err_vld`  out  1  set together with `first_err`.
- `wr_txn_cnt`, `rd_txn_cnt`  out  `CNT_WIDTH`  completed B handshakes and completed final R beats.
- `wr_beat_cnt`, `rd_beat_cnt`  out  `CNT_WIDTH`  W and R data handshakes.

## Operation
- A handshake is `VALID && READY`, sampled at the rising edge of `ACLK`.
- Error indices:
  - 0–4: `AW`/`W`/`B`/`AR`/`R` stability error.
  - 5: `WLAST_ERR`. 6: `RLAST_ERR`.
  - 7: `W_NO_AW`. 8: `B_UNEXP`. 9: `R_UNEXP`.
  - 10: `AW_OVF`. 11: `AR_OVF`.
- Stability check, per channel:
  - If `VALID && !READY` at edge n, then at edge n+1 `VALID` must be 1 and the payload must be unchanged.
  - Payload per channel: `AW` = addr+len; `W` = data+last; `B` = resp; `AR` = addr+len; `R` = data+last+resp.
- Write path:
  - An AW handshake pushes `AWLEN` into the write length FIFO.
  - Write FSM states are `W_IDLE` and `W_BURST`.
  - In `W_IDLE`, a W handshake pops the FIFO, loads the expected length and sets the beat counter to 0.
    - If the FIFO is empty, set `W_NO_AW` and ignore the beat for length checking.
  - Every W handshake checks `WLAST == (beat == len)`. A mismatch sets `WLAST_ERR`.
  - The burst ends at `beat == len` regardless of `WLAST`. The FSM then returns to `W_IDLE` and increments the `b_pending` counter (width log2(`MAX_OUTST`)+1).
  - A len-0 burst completes in a single beat without entering `W_BURST`.
- B handshake:
  - With `b_pending == 0`: set `B_UNEXP`.
  - Otherwise: decrement `b_pending` and increment `wr_txn_cnt`.
- Read path:
  - An AR handshake pushes `ARLEN` into the read length FIFO.
  - The R FSM mirrors the write FSM (`R_IDLE`, `R_BURST`).
  - An R handshake with the FIFO empty in `R_IDLE` sets `R_UNEXP`.
  - Every R beat checks `RLAST == (beat == len)`. A mismatch sets `RLAST_ERR`.
  - The final beat increments `rd_txn_cnt`.
- Overflow: an AW or AR handshake while its FIFO is full sets `AW_OVF` or `AR_OVF` and drops the entry.
- Same-edge events are handled as follows:
  - A push and pop on the same edge are both honoured; the FIFO count is unchanged.
  - A pop from an empty FIFO is not rescued by a same-edge push, so `W_NO_AW` is still set.
  - Full + same-edge pop + push is legal.
  - W completion and B handshake on the same edge leave `b_pending` unchanged, and no `B_UNEXP` is raised if `b_pending` is 0 before the edge.
- Counters saturate at all-ones.

## Timing
- All outputs are registered. An error sampled at edge n is visible on `err_sticky`, `err_pulse` and `first_err` after edge n.
- Counters update one cycle after the handshake.
- If several errors are detected on the first error edge, `first_err` takes the lowest index.
- `chk_clr` has priority over detection on the same edge: everything it clears becomes 0.
- Reset: every output is 0, both FSMs are in IDLE, the FIFOs are empty, `b_pending` is 0 and the stability history is cleared.
- An asynchronous `ARESETn` assertion mid-burst aborts tracking immediately. No error is raised for the aborted burst.

## Structure
- Package `axi4_chk_pkg` holds:
  - the error-index localparams and `ERR_W = 12`;
  - the FSM state typedef `burst_st_t` (IDLE, BURST), shared by both paths;
  - the OKAY response constant.
- Sub-module `axi4_chk_len_fifo`: a `MAX_OUTST`-deep, `LEN_WIDTH`-wide FIFO with full/empty outputs. It is instantiated twice, once for AW lengths and once for AR lengths.

## Test plan
- AW addr 0x010 len 3, then 4 W beats with `WLAST` on beat 4, then B OKAY → no error, `wr_beat_cnt` = 4, `wr_txn_cnt` = 1.
- AR len 1, then 2 R beats with `RLAST` on beat 1 → `RLAST_ERR`, `err_pulse` for 2 cycles, `first_err` = 6.
- `AWVALID` high with `AWREADY` low and `AWADDR` changing 0x004→0x008 → `err_sticky[0]`; then `chk_clr` → all outputs 0.
- 5 AW handshakes with no W traffic, `MAX_OUTST` = 4 → `AW_OVF` on the 5th. A W beat with an empty FIFO after reset → `W_NO_AW`.
- Final W beat and B handshake on the same edge with `b_pending` = 0 → no `B_UNEXP`, `wr_txn_cnt` +1. A B handshake with nothing pending → `B_UNEXP`.
- `ARESETn` pulsed low mid-read-burst → all outputs 0, FIFO empty, no error on resumed idle traffic.

Source files
------------

// File: rtl/axi4_chk_pkg.sv
// Shared definitions for the AXI4 protocol checker:
// error indices, burst tracker state and response codes.
package axi4_chk_pkg;

  localparam int ERR_W      = 12;
  localparam int E_AW_STAB  = 0;
  localparam int E_W_STAB   = 1;
  localparam int E_B_STAB   = 2;
  localparam int E_AR_STAB  = 3;
  localparam int E_R_STAB   = 4;
  localparam int E_WLAST    = 5;
  localparam int E_RLAST    = 6;
  localparam int E_W_NO_AW  = 7;
  localparam int E_B_UNEXP  = 8;
  localparam int E_R_UNEXP  = 9;
  localparam int E_AW_OVF   = 10;
  localparam int E_AR_OVF   = 11;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } burst_st_t;

  // Lowest set index wins when several errors fire together.
  function automatic logic [3:0] first_idx(
    input logic [ERR_W-1:0] v
  );
    first_idx = '0;
    for (int i = ERR_W - 1; i >= 0; i--)
      if (v[i]) first_idx = 4'(i);
  endfunction

endpackage

// File: rtl/axi4_chk_len_fifo.sv
// Burst-length FIFO; a full FIFO still accepts a push
// when a pop happens on the same edge.
module axi4_chk_len_fifo
  import axi4_chk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + (PW+1)'(1);
      if (pop_ok)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/axi4_protocol_checker.sv
// Passive AXI4 checker: burst tracking, stability and
// xLAST checks, sticky error flags and statistics.
module axi4_protocol_checker
  import axi4_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_OUTST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  chk_clr,
  input  logic                  AWVALID,
  input  logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [LEN_WIDTH-1:0]  AWLEN,
  input  logic                  WVALID,
  input  logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  BVALID,
  input  logic                  BREADY,
  input  logic [1:0]            BRESP,
  input  logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [LEN_WIDTH-1:0]  ARLEN,
  input  logic                  RVALID,
  input  logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RLAST,
  input  logic [1:0]            RRESP,
  output logic [ERR_W-1:0]      err_sticky,
  output logic                  err_pulse,
  output logic [3:0]            first_err,
  output logic                  first_err_vld,
  output logic [CNT_WIDTH-1:0]  wr_txn_cnt,
  output logic [CNT_WIDTH-1:0]  rd_txn_cnt,
  output logic [CNT_WIDTH-1:0]  wr_beat_cnt,
  output logic [CNT_WIDTH-1:0]  rd_beat_cnt
);

  localparam int AP  = ADDR_WIDTH + LEN_WIDTH;
  localparam int WP  = DATA_WIDTH + 1;
  localparam int RP  = DATA_WIDTH + 3;
  localparam int BPW = $clog2(MAX_OUTST) + 1;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  logic [4:0]    vld, rdy, chg, hold_q, stab_err;
  logic [AP-1:0] aw_p_q, ar_p_q;
  logic [WP-1:0] w_p_q;
  logic [1:0]    b_p_q;
  logic [RP-1:0] r_p_q;

  assign vld = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
  assign rdy = {RREADY, ARREADY, BREADY, WREADY, AWREADY};
  assign chg[0] = {AWADDR, AWLEN} != aw_p_q;
  assign chg[1] = {WDATA, WLAST} != w_p_q;
  assign chg[2] = BRESP != b_p_q;
  assign chg[3] = {ARADDR, ARLEN} != ar_p_q;
  assign chg[4] = {RDATA, RLAST, RRESP} != r_p_q;
  assign stab_err = hold_q & (~vld | chg);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      hold_q <= '0;
      aw_p_q <= '0;
      w_p_q  <= '0;
      b_p_q  <= '0;
      ar_p_q <= '0;
      r_p_q  <= '0;
    end else begin
      hold_q <= vld & ~rdy;
      aw_p_q <= {AWADDR, AWLEN};
      w_p_q  <= {WDATA, WLAST};
      b_p_q  <= BRESP;
      ar_p_q <= {ARADDR, ARLEN};
      r_p_q  <= {RDATA, RLAST, RRESP};
    end
  end

  logic                 aw_pop, aw_full, aw_empty;
  logic                 ar_pop, ar_full, ar_empty;
  logic [LEN_WIDTH-1:0] aw_head, ar_head;

  axi4_chk_len_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (LEN_WIDTH)
  ) u_aw_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .push_i  (aw_hs),
    .din_i   (AWLEN),
    .pop_i   (aw_pop),
    .dout_o  (aw_head),
    .full_o  (aw_full),
    .empty_o (aw_empty)
  );

  axi4_chk_len_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (LEN_WIDTH)
  ) u_ar_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .push_i  (ar_hs),
    .din_i   (ARLEN),
    .pop_i   (ar_pop),
    .dout_o  (ar_head),
    .full_o  (ar_full),
    .empty_o (ar_empty)
  );

  burst_st_t            w_st_q, w_st_d, r_st_q, r_st_d;
  logic [LEN_WIDTH-1:0] w_len_q, w_len_d, w_bt_q, w_bt_d;
  logic [LEN_WIDTH-1:0] r_len_q, r_len_d, r_bt_q, r_bt_d;
  logic                 wlast_err, w_no_aw, w_done;
  logic                 rlast_err, r_unexp, r_done;

  always_comb begin
    w_st_d    = w_st_q;
    w_len_d   = w_len_q;
    w_bt_d    = w_bt_q;
    aw_pop    = 1'b0;
    wlast_err = 1'b0;
    w_no_aw   = 1'b0;
    w_done    = 1'b0;
    if (w_hs) begin
      case (w_st_q)
        ST_IDLE: begin
          if (aw_empty) begin
            w_no_aw = 1'b1;
          end else begin
            aw_pop    = 1'b1;
            wlast_err = WLAST != (aw_head == '0);
            if (aw_head == '0) begin
              w_done = 1'b1;
            end else begin
              w_st_d  = ST_BURST;
              w_len_d = aw_head;
              w_bt_d  = LEN_WIDTH'(1);
            end
          end
        end
        ST_BURST: begin
          wlast_err = WLAST != (w_bt_q == w_len_q);
          if (w_bt_q == w_len_q) begin
            w_done = 1'b1;
            w_st_d = ST_IDLE;
          end else begin
            w_bt_d = w_bt_q + LEN_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    r_st_d    = r_st_q;
    r_len_d   = r_len_q;
    r_bt_d    = r_bt_q;
    ar_pop    = 1'b0;
    rlast_err = 1'b0;
    r_unexp   = 1'b0;
    r_done    = 1'b0;
    if (r_hs) begin
      case (r_st_q)
        ST_IDLE: begin
          if (ar_empty) begin
            r_unexp = 1'b1;
          end else begin
            ar_pop    = 1'b1;
            rlast_err = RLAST != (ar_head == '0);
            if (ar_head == '0) begin
              r_done = 1'b1;
            end else begin
              r_st_d  = ST_BURST;
              r_len_d = ar_head;
              r_bt_d  = LEN_WIDTH'(1);
            end
          end
        end
        ST_BURST: begin
          rlast_err = RLAST != (r_bt_q == r_len_q);
          if (r_bt_q == r_len_q) begin
            r_done = 1'b1;
            r_st_d = ST_IDLE;
          end else begin
            r_bt_d = r_bt_q + LEN_WIDTH'(1);
          end
        end
      endcase
    end
  end

  logic [BPW-1:0] bp_q, bp_d;
  logic           b_unexp, b_ok;

  // A burst finishing on the B edge covers that response.
  assign b_unexp = b_hs && (bp_q == '0) && !w_done;
  assign b_ok    = b_hs && !b_unexp;

  always_comb begin
    bp_d = bp_q;
    if (w_done && !b_ok && bp_q != '1)
      bp_d = bp_q + BPW'(1);
    else if (b_ok && !w_done)
      bp_d = bp_q - BPW'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_st_q  <= ST_IDLE;
      w_len_q <= '0;
      w_bt_q  <= '0;
      r_st_q  <= ST_IDLE;
      r_len_q <= '0;
      r_bt_q  <= '0;
      bp_q    <= '0;
    end else begin
      w_st_q  <= w_st_d;
      w_len_q <= w_len_d;
      w_bt_q  <= w_bt_d;
      r_st_q  <= r_st_d;
      r_len_q <= r_len_d;
      r_bt_q  <= r_bt_d;
      bp_q    <= bp_d;
    end
  end

  logic [ERR_W-1:0] err;
  always_comb begin
    err             = '0;
    err[4:0]        = stab_err;
    err[E_WLAST]    = wlast_err;
    err[E_RLAST]    = rlast_err;
    err[E_W_NO_AW]  = w_no_aw;
    err[E_B_UNEXP]  = b_unexp;
    err[E_R_UNEXP]  = r_unexp;
    err[E_AW_OVF]   = aw_hs && aw_full && !aw_pop;
    err[E_AR_OVF]   = ar_hs && ar_full && !ar_pop;
  end

  logic [ERR_W-1:0]     sticky_q;
  logic                 pulse_q, fev_q;
  logic [3:0]           fe_q;
  logic [CNT_WIDTH-1:0] wtx_q, rtx_q, wbt_q, rbt_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sticky_q <= '0;
      pulse_q  <= 1'b0;
      fe_q     <= '0;
      fev_q    <= 1'b0;
      wtx_q    <= '0;
      rtx_q    <= '0;
      wbt_q    <= '0;
      rbt_q    <= '0;
    end else if (chk_clr) begin
      sticky_q <= '0;
      pulse_q  <= 1'b0;
      fe_q     <= '0;
      fev_q    <= 1'b0;
      wtx_q    <= '0;
      rtx_q    <= '0;
      wbt_q    <= '0;
      rbt_q    <= '0;
    end else begin
      sticky_q <= sticky_q | err;
      pulse_q  <= |err;
      if (!fev_q && |err) begin
        fe_q  <= first_idx(err);
        fev_q <= 1'b1;
      end
      if (b_ok && wtx_q != '1)
        wtx_q <= wtx_q + CNT_WIDTH'(1);
      if (r_done && rtx_q != '1)
        rtx_q <= rtx_q + CNT_WIDTH'(1);
      if (w_hs && wbt_q != '1)
        wbt_q <= wbt_q + CNT_WIDTH'(1);
      if (r_hs && rbt_q != '1)
        rbt_q <= rbt_q + CNT_WIDTH'(1);
    end
  end

  assign err_sticky    = sticky_q;
  assign err_pulse     = pulse_q;
  assign first_err     = fe_q;
  assign first_err_vld = fev_q;
  assign wr_txn_cnt    = wtx_q;
  assign rd_txn_cnt    = rtx_q;
  assign wr_beat_cnt   = wbt_q;
  assign rd_beat_cnt   = rbt_q;

endmodule

// File: tb/tb_axi4_protocol_checker.sv
// Directed bench for axi4_protocol_checker with
// hand-computed expectations.
module tb_axi4_protocol_checker;
  import axi4_chk_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        chk_clr = 1'b0;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST;
  logic        BVALID, BREADY, ARVALID, ARREADY;
  logic        RVALID, RREADY, RLAST;
  logic [9:0]  AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;
  logic [11:0] err_sticky;
  logic        err_pulse, first_err_vld;
  logic [3:0]  first_err;
  logic [15:0] wr_txn_cnt, rd_txn_cnt;
  logic [15:0] wr_beat_cnt, rd_beat_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi4_protocol_checker dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .chk_clr       (chk_clr),
    .AWVALID       (AWVALID),
    .AWREADY       (AWREADY),
    .AWADDR        (AWADDR),
    .AWLEN         (AWLEN),
    .WVALID        (WVALID),
    .WREADY        (WREADY),
    .WDATA         (WDATA),
    .WLAST         (WLAST),
    .BVALID        (BVALID),
    .BREADY        (BREADY),
    .BRESP         (BRESP),
    .ARVALID       (ARVALID),
    .ARREADY       (ARREADY),
    .ARADDR        (ARADDR),
    .ARLEN         (ARLEN),
    .RVALID        (RVALID),
    .RREADY        (RREADY),
    .RDATA         (RDATA),
    .RLAST         (RLAST),
    .RRESP         (RRESP),
    .err_sticky    (err_sticky),
    .err_pulse     (err_pulse),
    .first_err     (first_err),
    .first_err_vld (first_err_vld),
    .wr_txn_cnt    (wr_txn_cnt),
    .rd_txn_cnt    (rd_txn_cnt),
    .wr_beat_cnt   (wr_beat_cnt),
    .rd_beat_cnt   (rd_beat_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle();
    AWVALID = 0; AWREADY = 0; AWADDR = '0; AWLEN = '0;
    WVALID = 0; WREADY = 0; WDATA = '0; WLAST = 0;
    BVALID = 0; BREADY = 0; BRESP = RESP_OKAY;
    ARVALID = 0; ARREADY = 0; ARADDR = '0; ARLEN = '0;
    RVALID = 0; RREADY = 0; RDATA = '0; RLAST = 0;
    RRESP = RESP_OKAY;
  endtask

  task automatic aw(input logic [9:0] a,
                    input logic [7:0] l);
    AWVALID = 1; AWREADY = 1; AWADDR = a; AWLEN = l;
    step();
    AWVALID = 0; AWREADY = 0;
  endtask

  task automatic ar(input logic [9:0] a,
                    input logic [7:0] l);
    ARVALID = 1; ARREADY = 1; ARADDR = a; ARLEN = l;
    step();
    ARVALID = 0; ARREADY = 0;
  endtask

  task automatic w(input logic [31:0] d, input logic l);
    WVALID = 1; WREADY = 1; WDATA = d; WLAST = l;
    step();
    WVALID = 0; WREADY = 0; WLAST = 0;
  endtask

  task automatic r(input logic [31:0] d, input logic l);
    RVALID = 1; RREADY = 1; RDATA = d; RLAST = l;
    step();
    RVALID = 0; RREADY = 0; RLAST = 0;
  endtask

  task automatic b();
    BVALID = 1; BREADY = 1; BRESP = RESP_OKAY;
    step();
    BVALID = 0; BREADY = 0;
  endtask

  task automatic clr();
    chk_clr = 1;
    step();
    chk_clr = 0;
  endtask

  task automatic rst_pulse();
    ARESETn = 0;
    step();
    ARESETn = 1;
    step();
  endtask

  initial begin
    idle();
    step();
    step();
    check("rst sticky", 32'(err_sticky), 0);
    check("rst pulse", 32'(err_pulse), 0);
    check("rst fevld", 32'(first_err_vld), 0);
    check("rst wtxn", 32'(wr_txn_cnt), 0);
    check("rst rbeat", 32'(rd_beat_cnt), 0);
    ARESETn = 1;
    step();

    aw(10'h010, 8'd3);
    for (int i = 0; i < 4; i++) w(32'(i), i == 3);
    b();
    check("wr sticky", 32'(err_sticky), 0);
    check("wr beats", 32'(wr_beat_cnt), 4);
    check("wr txns", 32'(wr_txn_cnt), 1);

    ar(10'h020, 8'd1);
    r(32'hA, 1'b1);
    check("rl pulse1", 32'(err_pulse), 1);
    check("rl first", 32'(first_err), 6);
    check("rl fevld", 32'(first_err_vld), 1);
    r(32'hB, 1'b0);
    check("rl pulse2", 32'(err_pulse), 1);
    check("rl sticky", 32'(err_sticky), 32'h040);
    step();
    check("rl pulse3", 32'(err_pulse), 0);
    check("rl rtxn", 32'(rd_txn_cnt), 1);
    check("rl rbeat", 32'(rd_beat_cnt), 2);
    clr();
    check("clr sticky", 32'(err_sticky), 0);
    check("clr fevld", 32'(first_err_vld), 0);
    check("clr rtxn", 32'(rd_txn_cnt), 0);
    check("clr wbeat", 32'(wr_beat_cnt), 0);

    AWVALID = 1; AWREADY = 0; AWADDR = 10'h004;
    step();
    AWADDR = 10'h008;
    step();
    check("stab sticky", 32'(err_sticky), 32'h001);
    check("stab first", 32'(first_err), 0);
    check("stab fevld", 32'(first_err_vld), 1);
    AWVALID = 0;
    step();
    clr();
    check("clr2 sticky", 32'(err_sticky), 0);
    check("clr2 pulse", 32'(err_pulse), 0);
    check("clr2 fevld", 32'(first_err_vld), 0);
    check("clr2 first", 32'(first_err), 0);

    rst_pulse();
    w(32'h1, 1'b1);
    check("noaw sticky", 32'(err_sticky), 32'h080);
    check("noaw first", 32'(first_err), 7);
    check("noaw wbeat", 32'(wr_beat_cnt), 1);
    clr();
    for (int i = 0; i < 4; i++) aw(10'(i * 4), 8'd0);
    check("fill sticky", 32'(err_sticky), 0);
    aw(10'h100, 8'd0);
    check("ovf sticky", 32'(err_sticky), 32'h400);
    check("ovf first", 32'(first_err), 10);
    clr();

    WVALID = 1; WREADY = 1; WLAST = 1;
    BVALID = 1; BREADY = 1; BRESP = RESP_OKAY;
    step();
    idle();
    check("wb sticky", 32'(err_sticky), 0);
    check("wb wtxn", 32'(wr_txn_cnt), 1);
    b();
    check("bun sticky", 32'(err_sticky), 32'h100);
    check("bun first", 32'(first_err), 8);
    clr();

    aw(10'h200, 8'd0);
    AWVALID = 1; AWREADY = 1; AWLEN = 8'd0;
    WVALID = 1; WREADY = 1; WLAST = 1;
    step();
    idle();
    check("fullpp sticky", 32'(err_sticky), 0);
    aw(10'h204, 8'd0);
    check("fullpp ovf", 32'(err_sticky), 32'h400);
    clr();

    rst_pulse();
    ar(10'h030, 8'd3);
    r(32'h11, 1'b0);
    check("ard rbeat", 32'(rd_beat_cnt), 1);
    #2;
    ARESETn = 0;
    #1;
    check("ard rbeat0", 32'(rd_beat_cnt), 0);
    check("ard sticky", 32'(err_sticky), 0);
    check("ard fevld", 32'(first_err_vld), 0);
    step();
    ARESETn = 1;
    step();
    step();
    check("idle sticky", 32'(err_sticky), 0);
    r(32'h22, 1'b1);
    check("runexp sticky", 32'(err_sticky), 32'h200);
    check("runexp first", 32'(first_err), 9);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
